// File: rtl/apb4_master_pkg.sv
// Shared types and default constants for the APB4 master bridge.
package apb4_master_pkg;

  // Transfer phases of the APB4 requester.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } fsm_t;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;   // legal values: 8, 16, 32
  localparam int DEF_TIMEOUT    = 256;  // 0 disables the stall abort

  // Width of the wait counter; a disabled timeout still gets a 1-bit counter
  // so that no zero-width vectors appear.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb4_master_bridge.sv
// APB4 requester: turns a valid/ready command stream into SETUP/ACCESS
// transfers and returns a valid/ready response. Handles pready wait states,
// forwards pslverr and aborts transfers that stall past TIMEOUT cycles.
module apb4_master_bridge
  import apb4_master_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  input  logic [2:0]              cmd_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_tmo_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int CNT_WIDTH = cnt_width(TIMEOUT);
  // Counter value seen on the last permitted stalled ACCESS cycle.
  localparam logic [CNT_WIDTH-1:0] TMO_LAST =
    CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  fsm_t                 state;
  fsm_t                 state_next;
  logic                 cmd_fire;
  logic                 xfer_done;
  logic                 tmo_hit;
  logic [CNT_WIDTH-1:0] wait_cnt;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks below use blocking (=).
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic and one-cycle transfer events.
  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    cmd_fire   = 1'b0;
    xfer_done  = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          cmd_fire   = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        // pready on the final allowed cycle takes priority over the abort.
        if (pready_i) begin
          xfer_done  = 1'b1;
          state_next = RESP;
        end else if ((TIMEOUT > 0) && (wait_cnt == TMO_LAST)) begin
          tmo_hit    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Consecutive stalled ACCESS cycles; restarts with each accepted command.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst)                                                wait_cnt <= '0;
    else if (cmd_fire)                                       wait_cnt <= '0;
    else if ((TIMEOUT > 0) && (state == ACCESS) && !pready_i) wait_cnt <= wait_cnt + 1'b1;
  end

  // Command capture; these drive the APB address/control/data directly and
  // hold their value until the next accepted command.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      paddr_o  <= '0;
      pwrite_o <= 1'b0;
      pwdata_o <= '0;
      pstrb_o  <= '0;
      pprot_o  <= '0;
    end else if (cmd_fire) begin
      paddr_o  <= cmd_addr_i;
      pwrite_o <= cmd_write_i;
      pwdata_o <= cmd_wdata_i;
      pstrb_o  <= cmd_write_i ? cmd_strb_i : '0;
      pprot_o  <= cmd_prot_i;
    end
  end

  // psel/penable registered from the next state so APB outputs never see a
  // combinational path from pready_i.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
    end else begin
      psel_o    <= (state_next == SETUP) || (state_next == ACCESS);
      penable_o <= (state_next == ACCESS);
    end
  end

  // Response capture at the end of ACCESS; held stable throughout RESP.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      rsp_tmo_o   <= 1'b0;
    end else if (xfer_done) begin
      rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
      rsp_err_o   <= pslverr_i;
      rsp_tmo_o   <= 1'b0;
    end else if (tmo_hit) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b1;
      rsp_tmo_o   <= 1'b1;
    end
  end

  assign cmd_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);

endmodule
